// File: rtl/cache_types_pkg.sv
// Shared types and encodings for the two-way L1 cache controller.
package cache_types_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TAG_CHECK = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_t;

  // Data array write source select.
  localparam logic DATA_SRC_CPU  = 1'b0;
  localparam logic DATA_SRC_PMEM = 1'b1;

  // Physical memory address source select.
  localparam logic ADDR_SEL_CPU = 1'b0;
  localparam logic ADDR_SEL_WB  = 1'b1;

  // One-hot per-way load mask for a way index.
  function automatic logic [1:0] way_mask(input logic way);
    if (way) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/cache_control.sv
// Sequencing controller for the two-way set-associative L1 cache: tag check,
// dirty-victim writeback, refill, and LRU/dirty maintenance.
module cache_control
  import cache_types_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  input  logic [1:0] hit,
  input  logic       lru_in,
  input  logic       dirty_in,
  output logic       array_read,
  output logic [1:0] tag_load,
  output logic [1:0] valid_load,
  output logic [1:0] dirty_load,
  output logic [1:0] data_load,
  output logic       dirty_datain,
  output logic       lru_load,
  output logic       lru_datain,
  output logic       data_src,
  output logic       pmem_addr_sel,
  output logic       victim_way
);

  state_t state_r;
  state_t state_next_s;
  logic   victim_way_r;
  logic   req_s;
  logic   hit_way_s;
  logic   miss_s;

  // A simultaneous read and write is handled as a write, so only the
  // presence of either request matters for sequencing.
  assign req_s      = mem_read | mem_write;
  assign miss_s     = (hit == 2'b00);
  assign victim_way = victim_way_r;

  // Pick the hitting way; way 0 wins if both report a hit.
  always_comb begin
    if (hit[0]) begin
      hit_way_s = 1'b0;
    end else begin
      hit_way_s = 1'b1;
    end
  end

  // State register and victim-way capture on a miss in TAG_CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      victim_way_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == S_TAG_CHECK) && req_s && miss_s) begin
        victim_way_r <= lru_in;
      end
    end
  end

  // Next-state and array/memory control decode.
  always_comb begin
    state_next_s  = state_r;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    array_read    = 1'b0;
    tag_load      = 2'b00;
    valid_load    = 2'b00;
    dirty_load    = 2'b00;
    data_load     = 2'b00;
    dirty_datain  = 1'b0;
    lru_load      = 1'b0;
    lru_datain    = 1'b0;
    data_src      = DATA_SRC_CPU;
    pmem_addr_sel = ADDR_SEL_CPU;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          array_read   = 1'b1;
          state_next_s = S_TAG_CHECK;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_TAG_CHECK: begin
        if (!req_s) begin
          // Request withdrawn (e.g. dropped during a refill): no response.
          state_next_s = S_IDLE;
        end else if (!miss_s) begin
          mem_resp     = 1'b1;
          lru_load     = 1'b1;
          lru_datain   = ~hit_way_s;
          state_next_s = S_IDLE;
          if (mem_write) begin
            data_load    = way_mask(hit_way_s);
            dirty_load   = way_mask(hit_way_s);
            dirty_datain = 1'b1;
            data_src     = DATA_SRC_CPU;
          end else begin
            dirty_datain = 1'b0;
          end
        end else if (dirty_in) begin
          state_next_s = S_WRITEBACK;
        end else begin
          state_next_s = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = ADDR_SEL_WB;
        if (pmem_resp) begin
          state_next_s = S_ALLOCATE;
        end else begin
          state_next_s = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = ADDR_SEL_CPU;
        if (pmem_resp) begin
          // Install the line and re-read; write-forward makes it hit next cycle.
          data_load    = way_mask(victim_way_r);
          tag_load     = way_mask(victim_way_r);
          valid_load   = way_mask(victim_way_r);
          dirty_load   = way_mask(victim_way_r);
          dirty_datain = 1'b0;
          data_src     = DATA_SRC_PMEM;
          array_read   = 1'b1;
          state_next_s = S_TAG_CHECK;
        end else begin
          state_next_s = S_ALLOCATE;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: a one-set cache model (valid, tag,
// dirty, LRU) plays the datapath and predicts every control output.
module tb_cache_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic       mem_write = 1'b0;
  logic       mem_resp;
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp = 1'b0;
  logic [1:0] hit = 2'b00;
  logic       lru_in = 1'b0;
  logic       dirty_in = 1'b0;
  logic       array_read;
  logic [1:0] tag_load;
  logic [1:0] valid_load;
  logic [1:0] dirty_load;
  logic [1:0] data_load;
  logic       dirty_datain;
  logic       lru_load;
  logic       lru_datain;
  logic       data_src;
  logic       pmem_addr_sel;
  logic       victim_way;

  cache_control dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit(hit), .lru_in(lru_in), .dirty_in(dirty_in),
    .array_read(array_read), .tag_load(tag_load), .valid_load(valid_load),
    .dirty_load(dirty_load), .data_load(data_load), .dirty_datain(dirty_datain),
    .lru_load(lru_load), .lru_datain(lru_datain), .data_src(data_src),
    .pmem_addr_sel(pmem_addr_sel), .victim_way(victim_way)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // One-set cache model
  logic       m_valid [2];
  logic       m_dirty [2];
  logic [3:0] m_tag   [2];
  logic       m_lru;
  logic [3:0] cur_tag;

  // Expected outputs for the current cycle
  logic       e_mem_resp, e_pmem_read, e_pmem_write, e_array_read;
  logic [1:0] e_tag_load, e_valid_load, e_dirty_load, e_data_load;
  logic       e_dirty_datain, e_lru_load, e_lru_datain, e_data_src, e_addr_sel;

  logic [16:0] obs_s;
  assign obs_s = {mem_resp, pmem_read, pmem_write, array_read, tag_load, valid_load,
                  dirty_load, data_load, dirty_datain, lru_load, lru_datain, data_src,
                  pmem_addr_sel};

  function automatic logic [1:0] mask_of(input int w);
    logic [1:0] m;
    m = (w == 0) ? 2'b01 : 2'b10;
    return m;
  endfunction

  function automatic int lookup(input logic [3:0] t);
    if (m_valid[0] && m_tag[0] == t) return 0;
    if (m_valid[1] && m_tag[1] == t) return 1;
    return -1;
  endfunction

  task automatic clr_exp();
    e_mem_resp = 1'b0; e_pmem_read = 1'b0; e_pmem_write = 1'b0; e_array_read = 1'b0;
    e_tag_load = 2'b00; e_valid_load = 2'b00; e_dirty_load = 2'b00; e_data_load = 2'b00;
    e_dirty_datain = 1'b0; e_lru_load = 1'b0; e_lru_datain = 1'b0; e_data_src = 1'b0;
    e_addr_sel = 1'b0;
  endtask

  // Datapath emulation from the model, then let outputs settle and compare.
  task automatic settle_chk(input string tag);
    logic [16:0] exp_v;
    hit[0]   = m_valid[0] && (m_tag[0] == cur_tag);
    hit[1]   = m_valid[1] && (m_tag[1] == cur_tag);
    lru_in   = m_lru;
    dirty_in = m_dirty[m_lru];
    #1;
    exp_v = {e_mem_resp, e_pmem_read, e_pmem_write, e_array_read, e_tag_load, e_valid_load,
             e_dirty_load, e_data_load, e_dirty_datain, e_lru_load, e_lru_datain, e_data_src,
             e_addr_sel};
    checks++;
    assert (obs_s === exp_v) else begin
      errors++;
      $error("FAIL %s outputs observed %h expected %h", tag, obs_s, exp_v);
    end
  endtask

  task automatic chk_victim(input string tag, input logic v);
    checks++;
    assert (victim_way === v) else begin
      errors++;
      $error("FAIL %s victim_way observed %b expected %b", tag, victim_way, v);
    end
  endtask

  task automatic expect_hit(input int w, input bit wr);
    e_mem_resp = 1'b1; e_lru_load = 1'b1; e_lru_datain = (w == 0);
    if (wr) begin
      e_data_load = mask_of(w); e_dirty_load = mask_of(w); e_dirty_datain = 1'b1;
    end
  endtask

  task automatic apply_hit(input int w, input bit wr);
    m_lru = (w == 0);
    if (wr) m_dirty[w] = 1'b1;
  endtask

  // One CPU transaction. drop_at/rst_at name an ALLOCATE cycle index, -1 = none.
  task automatic run_txn(input bit wr, input bit both, input logic [3:0] t,
                         input int lw, input int la, input int drop_at, input int rst_at);
    int  w;
    int  v;
    bit  dropped;
    dropped = 1'b0;
    cur_tag = t;
    @(negedge clk);
    mem_read = !wr || both; mem_write = wr; pmem_resp = 1'b0;
    clr_exp(); e_array_read = 1'b1;
    settle_chk("idle_accept");
    w = lookup(t);
    @(negedge clk);
    clr_exp();
    if (w >= 0) begin
      expect_hit(w, wr);
      settle_chk("tag_hit");
      apply_hit(w, wr);
    end else begin
      v = int'(m_lru);
      settle_chk("tag_miss");
      if (m_dirty[v]) begin
        for (int i = 0; i < lw; i++) begin
          @(negedge clk);
          pmem_resp = (i == lw - 1);
          clr_exp(); e_pmem_write = 1'b1; e_addr_sel = 1'b1;
          settle_chk("writeback");
          chk_victim("wb_victim", v[0]);
        end
      end
      for (int i = 0; i < la; i++) begin
        @(negedge clk);
        pmem_resp = (i == la - 1) && (rst_at < 0);
        if (i == drop_at) begin
          mem_read = 1'b0; mem_write = 1'b0; dropped = 1'b1;
        end
        if (i == rst_at) rst = 1'b1;
        clr_exp(); e_pmem_read = 1'b1;
        if (pmem_resp) begin
          e_data_load = mask_of(v); e_tag_load = mask_of(v); e_valid_load = mask_of(v);
          e_dirty_load = mask_of(v); e_data_src = 1'b1; e_array_read = 1'b1;
        end
        settle_chk(pmem_resp ? "refill" : "allocate");
        chk_victim("alloc_victim", v[0]);
        if (i == rst_at) begin
          @(negedge clk);
          rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
          clr_exp();
          settle_chk("rst_mid_alloc");
          chk_victim("rst_victim", 1'b0);
          return;
        end
        if (pmem_resp) begin
          m_tag[v] = t; m_valid[v] = 1'b1; m_dirty[v] = 1'b0;
        end
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      clr_exp();
      if (dropped) begin
        settle_chk("drop_no_resp");
      end else begin
        expect_hit(v, wr);
        settle_chk("post_refill_hit");
        apply_hit(v, wr);
      end
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    clr_exp();
    settle_chk("idle_after");
  endtask

  initial begin
    m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_dirty[0] = 1'b0; m_dirty[1] = 1'b0;
    m_tag[0] = 4'd0; m_tag[1] = 4'd0; m_lru = 1'b0; cur_tag = 4'd0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clr_exp();
    settle_chk("reset_outputs");
    chk_victim("reset_victim", 1'b0);
    rst = 1'b0;

    // Read hit on way 1 -> LRU points at way 0
    m_valid[1] = 1'b1; m_tag[1] = 4'd5;
    run_txn(1'b0, 1'b0, 4'd5, 1, 1, -1, -1);

    // Write hit on way 0
    m_valid[0] = 1'b1; m_tag[0] = 4'd6;
    run_txn(1'b1, 1'b0, 4'd6, 1, 1, -1, -1);

    // Both ways hit: way 0 wins
    m_tag[1] = 4'd6;
    run_txn(1'b0, 1'b0, 4'd6, 1, 1, -1, -1);
    m_tag[1] = 4'd5;

    // Clean miss, victim way 1, 5-cycle refill
    m_lru = 1'b1; m_dirty[1] = 1'b0;
    run_txn(1'b0, 1'b0, 4'd9, 1, 5, -1, -1);

    // Dirty miss, victim way 0, illegal read+write treated as write
    m_lru = 1'b0; m_dirty[0] = 1'b1;
    run_txn(1'b1, 1'b1, 4'd10, 3, 2, -1, -1);

    // Reset during ALLOCATE with victim way 1
    m_lru = 1'b1; m_dirty[1] = 1'b0;
    run_txn(1'b0, 1'b0, 4'd12, 1, 5, -1, 2);

    // Request dropped during ALLOCATE: line installed, no response
    m_lru = 1'b1; m_dirty[1] = 1'b0;
    run_txn(1'b0, 1'b0, 4'd13, 1, 4, 1, -1);
    // The installed line must now hit
    run_txn(1'b0, 1'b0, 4'd13, 1, 1, -1, -1);

    // Randomized traffic over a small tag space
    for (int n = 0; n < 40; n++) begin
      bit wr;
      wr = bit'($urandom_range(0, 1));
      run_txn(wr, wr && ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 3)),
              int'($urandom_range(1, 4)), int'($urandom_range(1, 5)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 0)) : -1, -1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        clr_exp();
        settle_chk("idle_gap");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
